// File: rtl/uart_apb_cfg_seq_if.sv
// APB bus between the UART config sequencer (master) and the UART register block (slave).
interface uart_apb_cfg_seq_if;
  logic [11:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uart_apb_cfg_seq.sv
// APB master that walks a table of write / read-and-compare entries to program the UART.
// Reports done, or error with the failing entry index and cause.
module uart_apb_cfg_seq #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                      pclk,
  input  logic                      prst_n,
  input  logic                      i_start,
  input  logic [4:0]                i_cfg_cnt,
  input  logic [12*NUM_ENTRIES-1:0] i_tbl_addr,
  input  logic [32*NUM_ENTRIES-1:0] i_tbl_data,
  input  logic [4*NUM_ENTRIES-1:0]  i_tbl_strb,
  input  logic [NUM_ENTRIES-1:0]    i_tbl_rd,
  uart_apb_cfg_seq_if.master        apb,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err,
  output logic [3:0]                o_err_idx,
  output logic [1:0]                o_err_code
);

  localparam int unsigned WcntW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StAccess, StDone, StErr} state_e;

  state_e           r_state, w_state_nxt;
  logic [3:0]       r_idx, w_idx_nxt;
  logic [4:0]       r_cnt, w_cnt_nxt;
  logic [WcntW-1:0] r_wcnt, w_wcnt_nxt;
  logic [3:0]       r_err_idx, w_err_idx_nxt;
  logic [1:0]       r_err_code, w_err_code_nxt;

  logic [11:0] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_rd;
  logic [31:0] w_mask;
  logic        w_mismatch;
  logic        w_apb_act;
  logic        w_wr_act;

  // Current entry fields; table inputs are held stable by the host while busy.
  always_comb begin
    w_addr     = i_tbl_addr[12*r_idx +: 12];
    w_data     = i_tbl_data[32*r_idx +: 32];
    w_strb     = i_tbl_strb[4*r_idx +: 4];
    w_rd       = i_tbl_rd[r_idx];
    w_mask     = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    w_mismatch = w_rd && (((apb.prdata ^ w_data) & w_mask) != 32'h0);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_wcnt_nxt     = r_wcnt;
    w_err_idx_nxt  = r_err_idx;
    w_err_code_nxt = r_err_code;
    unique case (r_state)
      StIdle, StDone, StErr: begin
        if (i_start) begin
          w_state_nxt    = StLoad;
          // Clamp so idx never walks past the table.
          w_cnt_nxt      = (i_cfg_cnt > 5'(NUM_ENTRIES)) ? 5'(NUM_ENTRIES) : i_cfg_cnt;
          w_idx_nxt      = 4'd0;
          w_err_idx_nxt  = 4'd0;
          w_err_code_nxt = 2'b00;
        end
      end
      StLoad: begin
        w_state_nxt = (r_cnt == 5'd0) ? StDone : StSetup;
      end
      StSetup: begin
        w_state_nxt = StAccess;
        w_wcnt_nxt  = '0;
      end
      StAccess: begin
        if (apb.pready) begin
          if (apb.pslverr) begin
            w_state_nxt    = StErr;
            w_err_idx_nxt  = r_idx;
            w_err_code_nxt = 2'b01;
          end else if (w_mismatch) begin
            w_state_nxt    = StErr;
            w_err_idx_nxt  = r_idx;
            w_err_code_nxt = 2'b11;
          end else if ({1'b0, r_idx} == r_cnt - 5'd1) begin
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StSetup;
            w_idx_nxt   = r_idx + 4'd1;
          end
        end else if (r_wcnt == WcntW'(TIMEOUT - 1)) begin
          w_state_nxt    = StErr;
          w_err_idx_nxt  = r_idx;
          w_err_code_nxt = 2'b10;
        end else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state    <= StIdle;
      r_idx      <= 4'd0;
      r_cnt      <= 5'd0;
      r_wcnt     <= '0;
      r_err_idx  <= 4'd0;
      r_err_code <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_err_idx  <= w_err_idx_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  // All outputs decode from registered state, so reset clears them asynchronously.
  assign w_apb_act   = (r_state == StSetup) || (r_state == StAccess);
  assign w_wr_act    = w_apb_act && !w_rd;
  assign apb.psel    = w_apb_act;
  assign apb.penable = (r_state == StAccess);
  assign apb.paddr   = w_apb_act ? w_addr : 12'h0;
  assign apb.pwrite  = w_wr_act;
  assign apb.pwdata  = w_wr_act ? w_data : 32'h0;
  assign apb.pstrb   = w_wr_act ? w_strb : 4'h0;

  assign o_busy     = (r_state == StLoad) || w_apb_act;
  assign o_done     = (r_state == StDone);
  assign o_err      = (r_state == StErr);
  assign o_err_idx  = r_err_idx;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_uart_apb_cfg_seq.sv
// Directed bench for uart_apb_cfg_seq: table walks, read compare, timeout, slave error, reset.
module tb_uart_apb_cfg_seq;
  localparam int unsigned NE = 8;

  logic              pclk;
  logic              prst_n;
  logic              i_start;
  logic [4:0]        i_cfg_cnt;
  logic [12*NE-1:0]  i_tbl_addr;
  logic [32*NE-1:0]  i_tbl_data;
  logic [4*NE-1:0]   i_tbl_strb;
  logic [NE-1:0]     i_tbl_rd;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [3:0]        o_err_idx;
  logic [1:0]        o_err_code;

  int n_total = 0;
  int n_bad   = 0;

  uart_apb_cfg_seq_if apb_if ();

  uart_apb_cfg_seq #(
    .NUM_ENTRIES(NE),
    .TIMEOUT    (16)
  ) u_dut (
    .pclk      (pclk),
    .prst_n    (prst_n),
    .i_start   (i_start),
    .i_cfg_cnt (i_cfg_cnt),
    .i_tbl_addr(i_tbl_addr),
    .i_tbl_data(i_tbl_data),
    .i_tbl_strb(i_tbl_strb),
    .i_tbl_rd  (i_tbl_rd),
    .apb       (apb_if),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_err_idx (o_err_idx),
    .o_err_code(o_err_code)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic rd);
    i_tbl_addr[12*i +: 12] = a;
    i_tbl_data[32*i +: 32] = d;
    i_tbl_strb[4*i +: 4]   = s;
    i_tbl_rd[i]            = rd;
  endtask

  // Pulse start across one edge; afterwards the DUT is in LOAD (cycle 1).
  task automatic kick(input logic [4:0] cnt);
    i_cfg_cnt = cnt;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int maxc);
    int n;
    n = 0;
    while (!(o_done || o_err) && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, o_done | o_err}, 32'd1);
  endtask

  initial begin
    int psel_cnt;
    int acc_cnt;
    prst_n     = 1'b0;
    i_start    = 1'b0;
    i_cfg_cnt  = 5'd0;
    i_tbl_addr = '0;
    i_tbl_data = '0;
    i_tbl_strb = '0;
    i_tbl_rd   = '0;
    apb_if.prdata  = 32'h0;
    apb_if.pready  = 1'b1;
    apb_if.pslverr = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_done", {31'b0, o_done}, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    chk("rst_psel", {31'b0, apb_if.psel}, 32'd0);
    chk("rst_code", {30'b0, o_err_code}, 32'd0);
    prst_n = 1'b1;
    tick();

    // Three writes, zero wait states.
    set_entry(0, 12'h000, 32'h0000_0011, 4'hF, 1'b0);
    set_entry(1, 12'h004, 32'h0000_0022, 4'h3, 1'b0);
    set_entry(2, 12'h008, 32'h0000_0033, 4'h1, 1'b0);
    kick(5'd3);
    chk("w3_load_busy", {31'b0, o_busy}, 32'd1);
    chk("w3_load_psel", {31'b0, apb_if.psel}, 32'd0);
    psel_cnt = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (apb_if.psel) psel_cnt++;
      if (c == 2) begin
        chk("w3_setup0_pen", {31'b0, apb_if.penable}, 32'd0);
        chk("w3_setup0_addr", {20'b0, apb_if.paddr}, 32'h000);
        chk("w3_setup0_wr", {31'b0, apb_if.pwrite}, 32'd1);
      end
      if (c == 5) begin
        chk("w3_acc1_pen", {31'b0, apb_if.penable}, 32'd1);
        chk("w3_acc1_data", apb_if.pwdata, 32'h0000_0022);
        chk("w3_acc1_strb", {28'b0, apb_if.pstrb}, 32'h3);
      end
      if (c == 7) chk("w3_c7_done", {31'b0, o_done}, 32'd0);
    end
    chk("w3_psel_cycles", psel_cnt, 32'd6);
    chk("w3_done", {31'b0, o_done}, 32'd1);
    chk("w3_err", {31'b0, o_err}, 32'd0);
    chk("w3_busy", {31'b0, o_busy}, 32'd0);

    // Write then read-back; upper bytes of prdata are masked out.
    set_entry(0, 12'h004, 32'h0000_00A5, 4'h1, 1'b0);
    set_entry(1, 12'h004, 32'h0000_00A5, 4'h1, 1'b1);
    apb_if.prdata = 32'hFFFF_FFA5;
    kick(5'd2);
    tick();
    tick();
    tick();
    chk("rd_setup_addr", {20'b0, apb_if.paddr}, 32'h004);
    chk("rd_setup_wr", {31'b0, apb_if.pwrite}, 32'd0);
    chk("rd_setup_wdata", apb_if.pwdata, 32'd0);
    chk("rd_setup_strb", {28'b0, apb_if.pstrb}, 32'd0);
    wait_end("rd_ok_end", 10);
    chk("rd_ok_done", {31'b0, o_done}, 32'd1);
    chk("rd_ok_err", {31'b0, o_err}, 32'd0);

    // Same read, low byte differs.
    apb_if.prdata = 32'h0000_00A4;
    kick(5'd2);
    wait_end("rd_bad_end", 10);
    chk("rd_bad_err", {31'b0, o_err}, 32'd1);
    chk("rd_bad_code", {30'b0, o_err_code}, 32'd3);
    chk("rd_bad_idx", {28'b0, o_err_idx}, 32'd1);
    chk("rd_bad_done", {31'b0, o_done}, 32'd0);

    // Entry 2 never becomes ready.
    set_entry(0, 12'h010, 32'h1, 4'hF, 1'b0);
    set_entry(1, 12'h014, 32'h2, 4'hF, 1'b0);
    set_entry(2, 12'h018, 32'h3, 4'hF, 1'b0);
    apb_if.pready = 1'b1;
    kick(5'd3);
    for (int k = 0; k < 5; k++) tick();
    chk("to_setup2_addr", {20'b0, apb_if.paddr}, 32'h018);
    apb_if.pready = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (apb_if.penable) acc_cnt++;
    end
    chk("to_acc_cycles", acc_cnt, 32'd16);
    chk("to_err", {31'b0, o_err}, 32'd1);
    chk("to_code", {30'b0, o_err_code}, 32'd2);
    chk("to_idx", {28'b0, o_err_idx}, 32'd2);
    chk("to_psel", {31'b0, apb_if.psel}, 32'd0);
    chk("to_busy", {31'b0, o_busy}, 32'd0);
    apb_if.pready = 1'b1;

    // Slave error on the first entry, then an empty walk clears it.
    apb_if.pslverr = 1'b1;
    kick(5'd3);
    wait_end("se_end", 10);
    chk("se_code", {30'b0, o_err_code}, 32'd1);
    chk("se_idx", {28'b0, o_err_idx}, 32'd0);
    apb_if.pslverr = 1'b0;
    kick(5'd0);
    chk("z_c1_err", {31'b0, o_err}, 32'd0);
    chk("z_c1_code", {30'b0, o_err_code}, 32'd0);
    chk("z_c1_done", {31'b0, o_done}, 32'd0);
    chk("z_c1_psel", {31'b0, apb_if.psel}, 32'd0);
    tick();
    chk("z_c2_done", {31'b0, o_done}, 32'd1);
    chk("z_c2_psel", {31'b0, apb_if.psel}, 32'd0);

    // Reset in the middle of a waited ACCESS.
    set_entry(0, 12'h00C, 32'h55, 4'hF, 1'b0);
    apb_if.pready = 1'b0;
    kick(5'd3);
    tick();
    tick();
    tick();
    chk("ar_in_access", {31'b0, apb_if.penable}, 32'd1);
    prst_n = 1'b0;
    #1;
    chk("ar_psel", {31'b0, apb_if.psel}, 32'd0);
    chk("ar_pen", {31'b0, apb_if.penable}, 32'd0);
    chk("ar_addr", {20'b0, apb_if.paddr}, 32'd0);
    chk("ar_busy", {31'b0, o_busy}, 32'd0);
    #1;
    prst_n = 1'b1;
    apb_if.pready = 1'b1;
    tick();
    kick(5'd3);
    tick();
    chk("ar_restart_psel", {31'b0, apb_if.psel}, 32'd1);
    chk("ar_restart_addr", {20'b0, apb_if.paddr}, 32'h00C);
    wait_end("ar_restart_end", 12);
    chk("ar_restart_done", {31'b0, o_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
